// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb : multi-read-port register file with busy scoreboard
//
// Holds NREGS registers of XLEN bits. It has NRD combinational read ports and
// two write ports; port 1 has priority over port 0. A per-register busy bit
// tracks pending producers between issue (alloc) and writeback (write).
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset (data and busy clear to 0)
//   rd_num     : NRD read addresses, port i at [i*AW +: AW]
//   rd_value   : NRD read data, port i at [i*XLEN +: XLEN]
//   rd_busy    : busy bit of each read address
//   wr_en      : write enables for write ports 0 and 1
//   wr_num     : write addresses, port k at [k*AW +: AW]
//   wr_value   : write data, port k at [k*XLEN +: XLEN]
//   alloc_en   : mark alloc_num busy
//   alloc_num  : register to mark busy
//   flush      : clear every busy bit
//
// Interface contract: there is no handshake or backpressure. Every enabled
// write, alloc and flush is accepted in the cycle it is presented.
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_num,
  output logic [NRD*XLEN-1:0]  rd_value,
  output logic [NRD-1:0]       rd_busy,
  input  logic [1:0]           wr_en,
  input  logic [2*AW-1:0]      wr_num,
  input  logic [2*XLEN-1:0]    wr_value,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_num,
  input  logic                 flush
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic [NREGS-1:0] w_busy_nxt;
  logic [NREGS-1:0] w_we0;
  logic [NREGS-1:0] w_we1;
  logic [1:0]       w_wr_ok;
  logic [AW-1:0]    w_wnum [2];
  logic [XLEN-1:0]  w_wval [2];

  assign w_wnum[0] = wr_num[0 +: AW];
  assign w_wnum[1] = wr_num[AW +: AW];
  assign w_wval[0] = wr_value[0 +: XLEN];
  assign w_wval[1] = wr_value[XLEN +: XLEN];

  // Per-register write decode and busy next-state. Only addresses that
  // match an implemented register decode, so out-of-range writes and allocs
  // fall away. Register 0 is skipped entirely when it is the zero register.
  // Order inside the loop makes alloc override a write clear; flush
  // overrides everything last.
  always_comb begin
    w_we0      = '0;
    w_we1      = '0;
    w_wr_ok    = '0;
    w_busy_nxt = r_busy;
    for (int r = 0; r < NREGS; r++) begin
      if (!((ZERO_REG != 0) && (r == 0))) begin
        if (wr_en[0] && (w_wnum[0] == AW'(r))) begin
          w_we0[r]   = 1'b1;
          w_wr_ok[0] = 1'b1;
        end
        if (wr_en[1] && (w_wnum[1] == AW'(r))) begin
          w_we1[r]   = 1'b1;
          w_wr_ok[1] = 1'b1;
        end
        if (w_we0[r] || w_we1[r]) w_busy_nxt[r] = 1'b0;
        if (alloc_en && (alloc_num == AW'(r))) w_busy_nxt[r] = 1'b1;
      end
    end
    if (flush) w_busy_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (w_we1[r])      r_regs[r] <= w_wval[1];
        else if (w_we0[r]) r_regs[r] <= w_wval[0];
      end
      r_busy <= w_busy_nxt;
    end
  end

  // Read ports. An address that matches no implemented register reads 0 and
  // not busy. The zero register is never written or allocated, so its stored
  // value and busy bit stay 0; w_wr_ok excludes it from bypass as well.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_val;
    logic            w_bsy;

    assign w_addr = rd_num[gi*AW +: AW];

    always_comb begin
      w_val = '0;
      w_bsy = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        if (w_addr == AW'(r)) begin
          w_val = r_regs[r];
          w_bsy = r_busy[r];
        end
      end
      if (BYPASS != 0) begin
        // Port 1 checked last so it wins when both ports hit this address.
        if (w_wr_ok[0] && (w_wnum[0] == w_addr)) begin
          w_val = w_wval[0];
          w_bsy = 1'b0;
        end
        if (w_wr_ok[1] && (w_wnum[1] == w_addr)) begin
          w_val = w_wval[1];
          w_bsy = 1'b0;
        end
      end
    end

    assign rd_value[gi*XLEN +: XLEN] = w_val;
    assign rd_busy[gi]               = w_bsy;
  end

endmodule
